// File: rtl/ifu.sv
// Instruction fetch unit: one-outstanding request/response fetch into a
// held instruction register, PC update on commit and halt on ebreak.
module ifu #(
  parameter logic [63:0] RESET_PC = 64'h0000_0000_8000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req_valid,
  output logic [63:0] imem_req_addr,
  input  logic        imem_req_ready,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  output logic        inst_valid,
  output logic [31:0] inst,
  output logic [63:0] pc,
  output logic [63:0] snpc,
  input  logic        commit,
  input  logic        pc_sel,
  input  logic [63:0] alu_result,
  input  logic        ebreak_flag,
  output logic        halted
);

  localparam logic [2:0] ST_BOOT  = 3'd0;
  localparam logic [2:0] ST_FETCH = 3'd1;
  localparam logic [2:0] ST_WAIT  = 3'd2;
  localparam logic [2:0] ST_EXEC  = 3'd3;
  localparam logic [2:0] ST_HALT  = 3'd4;

  logic [2:0]  state;
  logic [2:0]  state_nxt;
  logic [63:0] pc_q;
  logic [63:0] pc_nxt;
  logic [31:0] inst_q;
  logic [31:0] inst_nxt;
  logic [63:0] seq_pc;
  logic [63:0] jump_pc;

  assign seq_pc  = pc_q + 64'd4;
  // Targets are halfword aligned: bit 0 of the ALU result is dropped.
  assign jump_pc = alu_result & ~64'd1;

  always_comb begin
    state_nxt = state;
    pc_nxt    = pc_q;
    inst_nxt  = inst_q;
    case (state)
      ST_BOOT: begin
        state_nxt = ST_FETCH;
      end
      ST_FETCH: begin
        if (imem_req_ready) begin
          state_nxt = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (imem_resp_valid) begin
          inst_nxt  = imem_resp_data;
          state_nxt = ST_EXEC;
        end
      end
      ST_EXEC: begin
        if (commit) begin
          inst_nxt = NOP_INST;
          if (ebreak_flag) begin
            state_nxt = ST_HALT;
          end else begin
            pc_nxt    = pc_sel ? jump_pc : seq_pc;
            state_nxt = ST_FETCH;
          end
        end
      end
      ST_HALT: begin
        state_nxt = ST_HALT;
      end
      default: begin
        state_nxt = ST_BOOT;
        inst_nxt  = NOP_INST;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= ST_BOOT;
      pc_q   <= RESET_PC;
      inst_q <= NOP_INST;
    end else begin
      state  <= state_nxt;
      pc_q   <= pc_nxt;
      inst_q <= inst_nxt;
    end
  end

  assign imem_req_valid = (state == ST_FETCH);
  assign imem_req_addr  = pc_q;
  assign inst_valid     = (state == ST_EXEC);
  assign inst           = inst_q;
  assign pc             = pc_q;
  assign snpc           = seq_pc;
  assign halted         = (state == ST_HALT);

endmodule

// File: tb/tb_ifu.sv
// Directed bench for ifu with a transaction-level reference model checked
// every cycle, plus literal expectations at key points of the sequence.
module tb_ifu;

  localparam logic [63:0] RST_PC = 64'h0000_0000_8000_0000;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  logic        clk;
  logic        rst_n;
  logic        imem_req_valid;
  logic [63:0] imem_req_addr;
  logic        imem_req_ready;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        inst_valid;
  logic [31:0] inst;
  logic [63:0] pc;
  logic [63:0] snpc;
  logic        commit;
  logic        pc_sel;
  logic [63:0] alu_result;
  logic        ebreak_flag;
  logic        halted;

  int n_tests = 0;
  int n_fail  = 0;
  logic cmp_en = 1'b0;

  ifu #(.RESET_PC(RST_PC), .NOP_INST(NOP)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req_valid(imem_req_valid), .imem_req_addr(imem_req_addr),
    .imem_req_ready(imem_req_ready), .imem_resp_valid(imem_resp_valid),
    .imem_resp_data(imem_resp_data), .inst_valid(inst_valid), .inst(inst),
    .pc(pc), .snpc(snpc), .commit(commit), .pc_sel(pc_sel),
    .alu_result(alu_result), .ebreak_flag(ebreak_flag), .halted(halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: where the fetch transaction stands, what was fetched,
  // and the address of the instruction in flight.
  localparam int P_IDLE = 0, P_ASK = 1, P_AWAIT = 2, P_HOLD = 3, P_STOP = 4;
  int          m_phase;
  logic [63:0] m_pc;
  logic [31:0] m_inst;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_phase <= P_IDLE;
      m_pc    <= RST_PC;
      m_inst  <= NOP;
    end else begin
      if (m_phase == P_IDLE) m_phase <= P_ASK;
      else if (m_phase == P_ASK && imem_req_ready) m_phase <= P_AWAIT;
      else if (m_phase == P_AWAIT && imem_resp_valid) begin
        m_inst  <= imem_resp_data;
        m_phase <= P_HOLD;
      end else if (m_phase == P_HOLD && commit) begin
        m_inst <= NOP;
        if (ebreak_flag) m_phase <= P_STOP;
        else begin
          m_phase <= P_ASK;
          m_pc    <= pc_sel ? {alu_result[63:1], 1'b0} : m_pc + 64'd4;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      check("m_req_valid",  {63'd0, imem_req_valid}, {63'd0, m_phase == P_ASK});
      check("m_req_addr",   imem_req_addr, m_pc);
      check("m_inst_valid", {63'd0, inst_valid}, {63'd0, m_phase == P_HOLD});
      check("m_inst",       {32'd0, inst}, {32'd0, m_inst});
      check("m_pc",         pc, m_pc);
      check("m_snpc",       snpc, m_pc + 64'd4);
      check("m_halted",     {63'd0, halted}, {63'd0, m_phase == P_STOP});
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  // From FETCH: handshake, then respond the next cycle; commit noise is
  // asserted in both cycles and must be ignored.
  task automatic do_fetch(input logic [31:0] data);
    imem_req_ready = 1'b1;
    commit = 1'b1;
    step();
    imem_req_ready  = 1'b0;
    imem_resp_valid = 1'b1;
    imem_resp_data  = data;
    step();
    imem_resp_valid = 1'b0;
    commit = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b1;
    imem_req_ready = 1'b0; imem_resp_valid = 1'b0; imem_resp_data = '0;
    commit = 1'b0; pc_sel = 1'b0; alu_result = '0; ebreak_flag = 1'b0;
    #1 rst_n = 1'b0;
    #1 cmp_en = 1'b1;
    step(); step();
    check("rst_pc", pc, RST_PC);
    check("rst_snpc", snpc, 64'h8000_0004);
    check("rst_inst", {32'd0, inst}, {32'd0, NOP});
    check("rst_req_valid", {63'd0, imem_req_valid}, 64'd0);

    rst_n = 1'b1;
    step();
    check("boot_req_valid", {63'd0, imem_req_valid}, 64'd1);
    check("boot_req_addr", imem_req_addr, 64'h8000_0000);
    imem_req_ready = 1'b1;
    imem_resp_valid = 1'b1;      // same-cycle response must be ignored
    imem_resp_data = 32'hBAD0_0001;
    step();
    imem_req_ready = 1'b0;
    imem_resp_data = 32'h0010_0093;
    step();
    imem_resp_valid = 1'b0;
    check("first_inst_valid", {63'd0, inst_valid}, 64'd1);
    check("first_inst", {32'd0, inst}, 64'h0010_0093);

    commit = 1'b1; pc_sel = 1'b0;
    step();
    commit = 1'b0;
    check("seq_addr", imem_req_addr, 64'h8000_0004);
    check("seq_inst_nop", {32'd0, inst}, {32'd0, NOP});

    do_fetch(32'h0000_0013);
    commit = 1'b1; pc_sel = 1'b1; alu_result = 64'h8000_0101;
    step();
    commit = 1'b0; pc_sel = 1'b0;
    check("jump_addr", imem_req_addr, 64'h8000_0100);

    for (int i = 0; i < 5; i++) begin
      imem_resp_valid = (i == 2);
      imem_resp_data  = 32'hDEAD_0000;
      step();
      check("stall_req_valid", {63'd0, imem_req_valid}, 64'd1);
      check("stall_addr", imem_req_addr, 64'h8000_0100);
    end
    imem_resp_valid = 1'b0;
    do_fetch(32'h1234_5678);
    check("stall_inst", {32'd0, inst}, 64'h1234_5678);

    commit = 1'b1; pc_sel = 1'b1; alu_result = 64'hFFFF_FFFF_FFFF_FFFD;
    step();
    commit = 1'b0; pc_sel = 1'b0;
    check("wrap_pc", pc, 64'hFFFF_FFFF_FFFF_FFFC);
    check("wrap_snpc", snpc, 64'd0);
    do_fetch(32'h0000_0013);
    commit = 1'b1;
    step();
    commit = 1'b0;
    check("wrap_addr", imem_req_addr, 64'd0);

    do_fetch(32'h0010_0073);
    commit = 1'b1; ebreak_flag = 1'b1; pc_sel = 1'b1; alu_result = 64'h40;
    step();
    commit = 1'b0; ebreak_flag = 1'b0; pc_sel = 1'b0;
    check("halt_flag", {63'd0, halted}, 64'd1);
    check("halt_pc", pc, 64'd0);
    for (int i = 0; i < 4; i++) begin
      commit = 1'b1; imem_resp_valid = 1'b1; imem_req_ready = 1'b1;
      step();
      check("halt_no_req", {63'd0, imem_req_valid}, 64'd0);
      check("halt_stays", {63'd0, halted}, 64'd1);
    end
    commit = 1'b0; imem_resp_valid = 1'b0; imem_req_ready = 1'b0;

    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    imem_req_ready = 1'b1;
    step();
    imem_req_ready = 1'b0;
    rst_n = 1'b0;
    #1;
    check("midwait_req_valid", {63'd0, imem_req_valid}, 64'd0);
    check("midwait_pc", pc, RST_PC);
    check("midwait_inst", {32'd0, inst}, {32'd0, NOP});
    check("midwait_halted", {63'd0, halted}, 64'd0);
    imem_resp_valid = 1'b1; imem_resp_data = 32'hDEAD_BEEF;
    step(); step();
    imem_resp_valid = 1'b0;
    rst_n = 1'b1;
    step();
    check("restart_addr", imem_req_addr, RST_PC);
    check("restart_inst", {32'd0, inst}, {32'd0, NOP});
    imem_req_ready = 1'b1;
    step();
    imem_req_ready = 1'b0;
    check("restart_wait_inst", {32'd0, inst}, {32'd0, NOP});
    imem_resp_valid = 1'b1; imem_resp_data = 32'h0020_0113;
    step();
    imem_resp_valid = 1'b0;
    check("restart_new_inst", {32'd0, inst}, 64'h0020_0113);
    commit = 1'b1;
    step();
    commit = 1'b0;
    step(); step();
    cmp_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
